// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock sequencer: drives pll_rst, syncs locked, gates sys_rst.
// Optional lock-loss counter: PLL_RESET_SEQUENCER_LOSS_COUNT_EN.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int unsigned MAX_AB =
    (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_C =
    (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned TW = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [TW-1:0] T_PLL  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_STB  = TW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    R_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [3:0]      retry_n;
  logic            loss_inc;
  logic [SYNC_STAGES-1:0] sync_q;
  logic            locked_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_n  = state;
    timer_n  = timer + 1'b1;
    retry_n  = retry_count;
    loss_inc = 1'b0;
    unique case (state)
      S_PLL_RST: begin
        if (timer == T_PLL) state_n = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_n = S_STABLE;
        end else if (timer == T_LOCK) begin
          if (retry_count == R_MAX) begin
            state_n = S_FAIL;
          end else begin
            retry_n = retry_count + 1'b1;
            state_n = S_PLL_RST;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_n = S_WAIT_LOCK;
        end else if (timer == T_STB) begin
          state_n = S_RUN;
          retry_n = '0;
        end
      end
      S_RUN: begin
        timer_n = '0;
        if (!locked_s) begin
          state_n  = S_WAIT_LOCK;
          loss_inc = 1'b1;
        end
      end
      S_FAIL: begin
        timer_n = '0;
      end
      default: begin
        state_n = S_PLL_RST;
      end
    endcase
    // restart overrides state logic but a coincident loss still counts
    if (restart) begin
      state_n = S_PLL_RST;
      retry_n = '0;
    end
    if (restart || (state_n != state)) timer_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_PLL_RST;
      timer       <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      retry_count <= retry_n;
      pll_rst     <= (state_n == S_PLL_RST) || (state_n == S_FAIL);
      sys_rst     <= (state_n != S_RUN);
      ready       <= (state_n == S_RUN);
      fail        <= (state_n == S_FAIL);
    end
  end

`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_q <= '0;
    end else if (loss_inc && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign loss_count = loss_q;
`else
  logic unused_loss_inc;
  assign unused_loss_inc = loss_inc;
  assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer.
// Expected loss counts follow PLL_RESET_SEQUENCER_LOSS_COUNT_EN.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  int checks = 0;
  int passed = 0;
  int n;
  int bad;

  pll_reset_sequencer #(
    .SYNC_STAGES(2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8),
    .MAX_RETRIES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .locked(locked),
    .restart(restart),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .fail(fail),
    .retry_count(retry_count),
    .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  function automatic int loss_exp(input int k);
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
    return (k > 255) ? 255 : k;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0: return pll_rst;
      1: return sys_rst;
      2: return ready;
      default: return fail;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, output int cnt);
    cnt = 0;
    while (cnt < 200) begin
      tick();
      cnt++;
      if (pick(sel) === val) break;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    locked = 1'b0;
    restart = 1'b0;
    repeat (3) tick();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_retry", retry_count, 0);
    chk("rst_loss", loss_count, 0);

    rst = 1'b0;
    wait_sig(0, 1'b0, n);
    chk("pll_rst_len", n, 4);
    chk("wait_sys_rst", sys_rst, 1);
    repeat (10) tick();
    locked = 1'b1;
    wait_sig(2, 1'b1, n);
    chk("lock_to_ready", n, 11);
    chk("run_sys_rst", sys_rst, 0);
    chk("run_pll_rst", pll_rst, 0);
    chk("run_retry", retry_count, 0);

    locked = 1'b0;
    wait_sig(1, 1'b1, n);
    chk("loss_latency", n, 3);
    chk("loss_ready", ready, 0);
    chk("loss_count_1", loss_count, loss_exp(1));
    locked = 1'b1;
    wait_sig(2, 1'b1, n);
    chk("relock_ready", n, 11);

    locked = 1'b0;
    wait_sig(1, 1'b1, n);
    chk("loss2_latency", n, 3);
    locked = 1'b1;
    repeat (5) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    chk("glitch_no_ready", ready, 0);
    wait_sig(2, 1'b1, n);
    chk("unstable_release", n, 11);
    chk("unstable_retry", retry_count, 0);
    chk("loss_count_2", loss_count, loss_exp(2));

    locked = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_run_pll_rst", pll_rst, 1);
    chk("rs_run_sys_rst", sys_rst, 1);
    chk("rs_run_ready", ready, 0);
    chk("rs_run_retry", retry_count, 0);
    chk("rs_run_loss", loss_count, loss_exp(2));

    wait_sig(0, 1'b0, n);
    chk("to_pulse0", n, 4);
    wait_sig(0, 1'b1, n);
    chk("to_wait0", n, 32);
    chk("to_retry1", retry_count, 1);
    wait_sig(0, 1'b0, n);
    chk("to_pulse1", n, 4);
    wait_sig(0, 1'b1, n);
    chk("to_wait1", n, 32);
    chk("to_retry2", retry_count, 2);
    wait_sig(0, 1'b0, n);
    chk("to_pulse2", n, 4);
    wait_sig(3, 1'b1, n);
    chk("to_fail", n, 32);
    chk("fail_pll_rst", pll_rst, 1);
    chk("fail_sys_rst", sys_rst, 1);
    chk("fail_retry", retry_count, 2);
    repeat (40) tick();
    chk("fail_hold", fail, 1);
    chk("fail_hold_pll", pll_rst, 1);

    locked = 1'b1;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_fail_pll_rst", pll_rst, 1);
    chk("rs_fail_fail", fail, 0);
    chk("rs_fail_retry", retry_count, 0);
    chk("rs_fail_sys_rst", sys_rst, 1);
    chk("rs_fail_loss", loss_count, loss_exp(2));

    repeat (8) tick();
    chk("stable_sys_rst", sys_rst, 1);
    rst = 1'b1;
    restart = 1'b1;
    tick();
    chk("mid_rst_pll_rst", pll_rst, 1);
    chk("mid_rst_sys_rst", sys_rst, 1);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_fail", fail, 0);
    chk("mid_rst_retry", retry_count, 0);
    chk("mid_rst_loss", loss_count, 0);
    rst = 1'b0;
    restart = 1'b0;
    wait_sig(2, 1'b1, n);
    chk("post_rst_ready", n, 13);

    locked = 1'b0;
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("loss_rs_pll_rst", pll_rst, 1);
    chk("loss_rs_ready", ready, 0);
    chk("loss_rs_count", loss_count, loss_exp(1));
    locked = 1'b1;
    wait_sig(2, 1'b1, n);
    chk("loss_rs_ready_lat", n, 13);

    bad = 0;
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      wait_sig(1, 1'b1, n);
      if (n != 3) bad++;
      locked = 1'b1;
      wait_sig(2, 1'b1, n);
      if (n != 11) bad++;
    end
    chk("sat_timing", bad, 0);
    chk("sat_loss", loss_count, loss_exp(301));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumer end of the PLL `rst`/`locked` interface.
- Runs on a free-running board clock (not a PLL output). Drives the PLL reset and synchronizes the asynchronous `locked` flag.
- Holds the core's system reset until lock has been stable for a programmed time.
- Retries PLL reset on lock timeout, flags permanent failure, and re-asserts system reset on lock loss.

Parameters:
- SYNC_STAGES, 2: flops in the `locked` synchronizer chain; minimum 2.
- PLL_RST_CYCLES, 16: clocks `pll_rst` is held high per attempt; minimum 1.
- LOCK_TIMEOUT, 65536: clocks to wait for lock before retrying.
- STABLE_CYCLES, 1024: consecutive synchronized-locked clocks required before release.
- MAX_RETRIES, 4: PLL reset retries before entering FAIL; maximum 15.

Ports:
- clk  in  1  free-running reference clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  PLL lock flag; asynchronous to `clk`.
- restart  in  1  one-cycle request to restart the full sequence.
- pll_rst  out  1  reset to the PLL, active high.
- sys_rst  out  1  system reset to the core, active high.
- ready  out  1  high while in RUN.
- fail  out  1  high while in FAIL.
- retry_count  out  4  retries used in the current attempt.
- loss_count  out  8  lock-loss events (see Optional Feature).

Behaviour:
- Clocking and reset: one clock `clk`; `rst` is synchronous, active-high. Every output is registered.
- Values under `rst`: state=PLL_RST, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_count=0, loss_count=0, timer=0, synchronizer=0.
- Synchronizer: `locked` passes through SYNC_STAGES flops to give `locked_s`. Nothing else samples raw `locked`.
- Timer: single shared counter, width $clog2 of the largest cycle parameter. Cleared on every state transition.
- PLL_RST:
  - pll_rst=1, sys_rst=1.
  - After PLL_RST_CYCLES clocks in this state, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - If `locked_s`=1, go to STABLE.
  - Else, when timer==LOCK_TIMEOUT-1: if retry_count==MAX_RETRIES, go to FAIL; otherwise retry_count+1 and go to PLL_RST.
- STABLE:
  - pll_rst=0, sys_rst=1.
  - If `locked_s`=0, go back to WAIT_LOCK. This is not a retry; retry_count is unchanged.
  - When timer==STABLE_CYCLES-1 with `locked_s`=1, go to RUN.
- RUN:
  - sys_rst=0 and ready=1, from the first cycle in RUN. retry_count is cleared on entry.
  - If `locked_s`=0: go to WAIT_LOCK. sys_rst=1 and ready=0 at the next edge. loss_count increments and saturates at 255.
  - Worst-case latency from a `locked` fall to sys_rst high: SYNC_STAGES+1 clocks.
- FAIL:
  - pll_rst=1, sys_rst=1, fail=1.
  - Leaves only on `rst` or `restart`.
- restart, in any state: go to PLL_RST at the next edge with retry_count=0, sys_rst=1, ready=0, fail=0. loss_count is retained.
- Precedence: `rst` over `restart` over all state logic. A lock loss in RUN coinciding with `restart` goes to PLL_RST; loss_count still increments.
- Glitches: a `locked` pulse shorter than one clock may be missed; this is acceptable. A pulse that reaches `locked_s` always takes effect.

Optional Feature:
- Macro: PLL_RESET_SEQUENCER_LOSS_COUNT_EN.
- Defined: loss_count behaves as described above.
- Undefined: the loss_count register is not built and the port is tied to 8'd0. All other behaviour is identical.

Test Plan:
Parameters for all scenarios: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Normal lock: release `rst`; `locked` rises 10 clocks after pll_rst falls -> pll_rst high exactly 4 clocks; sys_rst falls and ready rises 2+8 clocks after the `locked` rise (±1); retry_count=0.
- Timeout with retries: `locked` held 0 -> two PLL_RST pulses of 4 clocks, each 32 clocks apart; retry_count reads 1 then 2; after the third timeout, fail=1, pll_rst=1, sys_rst=1 and stay.
- Unstable lock: `locked` high 5 clocks, low 1, then high -> no release until 8 consecutive synchronized-high clocks; retry_count unchanged.
- Lock loss in RUN: drop `locked` -> sys_rst=1 and ready=0 within 3 clocks; loss_count 0 to 1; re-lock gives release after 8 stable clocks; 300 losses leave loss_count=255 (or 0 with the macro undefined).
- restart from FAIL and from RUN -> PLL_RST next clock; retry_count=0; fail=0; loss_count retained.
- `rst` asserted mid-STABLE together with `restart` -> all reset values at the next edge; `rst` wins.
